// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- 640x480@60 Hz VGA timing generator on the 50 MHz board clock.
//
// A registered toggle divides clock_50M by two. The pixel counters advance on
// every second clock_50M edge, when pix_en is high. All sync/enable outputs
// are decoded combinationally from the counter registers, so they line up
// with sx/sy at zero latency.
//
// Ports:
//   clock_50M    in   system clock, all logic on its rising edge
//   reset_n      in   asynchronous active-low reset
//   clock_25M    out  divided clock for the VGA DAC (registered toggle)
//   pix_en       out  high on the clock_50M edge where the counters advance
//   sx           out  horizontal counter, 0 .. line total - 1
//   sy           out  vertical counter, 0 .. frame total - 1
//   hsync        out  horizontal sync, active level SYNC_POL
//   vsync        out  vertical sync, active level SYNC_POL
//   de           out  display enable, high inside the visible area
//   frame        out  high at (0, V_ACTIVE), start of vertical blanking
//   frame_count  out  16-bit wrapping frame counter, present only when the
//                     VGA_FRAME_CNT_EN macro is defined
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clock_50M,
  input  logic       reset_n,
  output logic       clock_25M,
  output logic       pix_en,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic line_end;
  logic frame_end;

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      clock_25M <= 1'b0;
    end else begin
      clock_25M <= ~clock_25M;
    end
  end

  // Counters move on the edge where clock_25M is currently high, which is
  // also the edge that drives clock_25M low again.
  always_comb begin
    pix_en    = clock_25M;
    line_end  = (sx == H_LAST);
    frame_end = line_end && (sy == V_LAST);
  end

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      sx <= '0;
      sy <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        sx <= '0;
        sy <= (sy == V_LAST) ? '0 : sy + 10'd1;
      end else begin
        sx <= sx + 10'd1;
      end
    end
  end

  always_comb begin
    hsync = ((sx >= HS_FIRST) && (sx <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync = ((sy >= VS_FIRST) && (sy <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    de    = (sx < H_ACT) && (sy < V_ACT);
    frame = (sy == V_ACT) && (sx == '0);
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (pix_en && frame_end) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. The full-size instance covers reset,
// divider, line timing and mid-frame reset; a reduced-geometry instance
// (24 x 15 total) covers vertical sync, the frame strobe and the frame wrap
// within a short run.
module tb_vga_timing_gen;

  logic       clk;
  logic       reset_n;
  logic       reset_n_s;

  logic       clock_25M, pix_en, hsync, vsync, de, frame;
  logic [9:0] sx, sy;
  logic       clock_25M_s, pix_en_s, hsync_s, vsync_s, de_s, frame_s;
  logic [9:0] sx_s, sy_s;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count, frame_count_s;
`endif

  int n_pass  = 0;
  int n_total = 0;

  vga_timing_gen dut (
    .clock_50M (clk),
    .reset_n   (reset_n),
    .clock_25M (clock_25M),
    .pix_en    (pix_en),
    .sx        (sx),
    .sy        (sy),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .frame     (frame)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  // Reduced geometry: line total 24 (hsync 18..21), frame total 15 (vsync 10..11).
  vga_timing_gen #(
    .H_ACTIVE (16),
    .H_FP     (2),
    .H_SYNC   (4),
    .H_BP     (2),
    .V_ACTIVE (8),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3),
    .SYNC_POL (1'b0)
  ) dut_small (
    .clock_50M (clk),
    .reset_n   (reset_n_s),
    .clock_25M (clock_25M_s),
    .pix_en    (pix_en_s),
    .sx        (sx_s),
    .sy        (sy_s),
    .hsync     (hsync_s),
    .vsync     (vsync_s),
    .de        (de_s),
    .frame     (frame_s)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_count (frame_count_s)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  initial begin
    int h_low_cnt, h_low_first, h_low_last, de_fall;
    int v_low_cnt, v_low_first, v_low_last, fr_cnt, fr_sx, fr_sy;

    reset_n   = 1'b0;
    reset_n_s = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_clk25", clock_25M, 0);
    check("rst_pix_en", pix_en, 0);
    check("rst_sx", sx, 0);
    check("rst_sy", sy, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_de", de, 1);
    check("rst_frame", frame, 0);
`ifdef VGA_FRAME_CNT_EN
    check("rst_frame_count", frame_count, 0);
`endif

    // Divider: after k edges, clock_25M = pix_en = k%2 and sx = k/2
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("div_clk25", clock_25M, k % 2);
      check("div_pix_en", pix_en, k % 2);
      if (k % 2 == 0) check("div_sx", sx, k / 2);
    end
    check("div_sx_end", sx, 10);

    // Line 0 timing
    h_low_cnt = 0; h_low_first = -1; h_low_last = -1; de_fall = -1;
    for (int k = 21; k <= 1600; k++) begin
      @(negedge clk);
      if (!hsync) begin
        h_low_cnt++;
        if (h_low_first < 0) h_low_first = int'(sx);
        h_low_last = int'(sx);
      end
      if (!de && de_fall < 0) de_fall = int'(sx);
      if (k == 1598) begin
        check("line_sx_799", sx, 799);
        check("line_sy_0", sy, 0);
      end
    end
    check("de_fall_sx", de_fall, 640);
    check("hsync_first_sx", h_low_first, 656);
    check("hsync_last_sx", h_low_last, 751);
    check("hsync_low_cycles", h_low_cnt, 192);
    check("wrap_sx", sx, 0);
    check("wrap_sy", sy, 1);
    check("wrap_de", de, 1);
    check("wrap_hsync", hsync, 1);

    // Advance to (300,1), then reset between edges
    repeat (600) @(negedge clk);
    check("pre_rst_sx", sx, 300);
    check("pre_rst_sy", sy, 1);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_sx", sx, 0);
    check("mid_rst_sy", sy, 0);
    check("mid_rst_clk25", clock_25M, 0);
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_de", de, 1);
    repeat (3) @(negedge clk);
    check("hold_rst_sx", sx, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("resume1_clk25", clock_25M, 1);
    check("resume1_sx", sx, 0);
    @(negedge clk);
    check("resume2_clk25", clock_25M, 0);
    check("resume2_sx", sx, 1);
    check("resume2_sy", sy, 0);

    // Reduced-geometry frame: 24*15 pixels = 720 edges
    check("small_rst_sx", sx_s, 0);
    check("small_rst_vsync", vsync_s, 1);
    reset_n_s = 1'b1;
    v_low_cnt = 0; v_low_first = -1; v_low_last = -1;
    fr_cnt = 0; fr_sx = -1; fr_sy = -1;
    for (int k = 1; k <= 720; k++) begin
      @(negedge clk);
      if (!vsync_s) begin
        v_low_cnt++;
        if (v_low_first < 0) v_low_first = int'(sy_s);
        v_low_last = int'(sy_s);
      end
      if (frame_s) begin
        fr_cnt++;
        fr_sx = int'(sx_s);
        fr_sy = int'(sy_s);
      end
      if (k == 718) begin
        check("small_last_sx", sx_s, 23);
        check("small_last_sy", sy_s, 14);
`ifdef VGA_FRAME_CNT_EN
        check("small_fc_before", frame_count_s, 0);
`endif
      end
    end
    check("vsync_first_sy", v_low_first, 10);
    check("vsync_last_sy", v_low_last, 11);
    check("vsync_low_cycles", v_low_cnt, 96);
    check("frame_cycles", fr_cnt, 2);
    check("frame_sx", fr_sx, 0);
    check("frame_sy", fr_sy, 8);
    check("small_wrap_sx", sx_s, 0);
    check("small_wrap_sy", sy_s, 0);
    check("small_wrap_de", de_s, 1);
`ifdef VGA_FRAME_CNT_EN
    check("small_fc_after", frame_count_s, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
